// File: rtl/cluster_pkg.sv
// Shared types for the per-core dispatcher port.
// Address width and the launch/emit state encodings.
package cluster_pkg;
  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    ACTIVE
  } launch_state_t;

  typedef enum logic {
    E_IDLE,
    E_HOLD
  } emit_state_t;
endpackage

// File: rtl/proc_port_if.sv
// Core-side bundle of a proc_port: launch pulse/entry,
// completion, and the spawn valid/ready handshake.
interface proc_port_if;
  import cluster_pkg::*;

  logic  core_go;
  addr_t core_entry;
  logic  core_done;
  logic  core_spawn_valid;
  addr_t core_spawn_addr;
  logic  core_spawn_ready;

  modport master (
    output core_go,
    output core_entry,
    output core_spawn_ready,
    input  core_done,
    input  core_spawn_valid,
    input  core_spawn_addr
  );

  modport slave (
    input  core_go,
    input  core_entry,
    input  core_spawn_ready,
    output core_done,
    output core_spawn_valid,
    output core_spawn_addr
  );
endinterface

// File: rtl/spawn_fifo.sv
// Show-ahead spawn request FIFO; also exports the
// next-cycle empty flag for the registered busy output.
module spawn_fifo
  import cluster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  addr_t din,
  input  logic  pop,
  output addr_t dout,
  output logic  full,
  output logic  empty,
  output logic  empty_nxt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  addr_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_ONE;
    end
    empty_nxt = (count_nxt == '0);
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/proc_port.sv
// Dispatcher-to-core port: start-edge launch FSM plus a
// spawn emitter that holds each toggle event HOLD_CYCLES.
module proc_port
  import cluster_pkg::*;
#(
  parameter int SPAWN_DEPTH = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  proc_start,
  input  addr_t proc_start_addr,
  output logic  proc_running,
  output addr_t proc_spawn_addr,
  output logic  proc_onspawn,
  output logic  launch_err,
  proc_port_if.master core
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  launch_state_t launch_q;
  launch_state_t launch_nxt;
  emit_state_t   emit_q;
  emit_state_t   emit_nxt;
  logic [HW-1:0] hold_cnt;
  logic          start_prev;
  logic          start_edge;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_empty_nxt;
  logic          push;
  logic          pop;
  addr_t         fifo_head;

  assign start_edge            = proc_start & ~start_prev;
  assign core.core_spawn_ready = ~fifo_full;
  assign push = core.core_spawn_valid & ~fifo_full;
  assign pop  = (emit_q == E_IDLE) & ~fifo_empty;

  spawn_fifo #(
    .DEPTH(SPAWN_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .din      (core.core_spawn_addr),
    .pop      (pop),
    .dout     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .empty_nxt(fifo_empty_nxt)
  );

  always_comb begin
    launch_nxt = launch_q;
    unique case (launch_q)
      IDLE:    if (start_edge) launch_nxt = LAUNCH;
      LAUNCH:  launch_nxt = ACTIVE;
      ACTIVE:  if (core.core_done) launch_nxt = IDLE;
      default: launch_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit_nxt = emit_q;
    unique case (emit_q)
      E_IDLE:  if (pop) emit_nxt = E_HOLD;
      E_HOLD:  if (hold_cnt == '0) emit_nxt = E_IDLE;
      default: emit_nxt = E_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      launch_q        <= IDLE;
      emit_q          <= E_IDLE;
      hold_cnt        <= '0;
      start_prev      <= 1'b0;
      core.core_go    <= 1'b0;
      core.core_entry <= '0;
      launch_err      <= 1'b0;
      proc_spawn_addr <= '0;
      proc_onspawn    <= 1'b0;
      proc_running    <= 1'b0;
    end else begin
      launch_q     <= launch_nxt;
      emit_q       <= emit_nxt;
      start_prev   <= proc_start;
      core.core_go <= (launch_nxt == LAUNCH);
      if (launch_q == IDLE && start_edge) begin
        core.core_entry <= proc_start_addr;
      end
      if (launch_q != IDLE && start_edge) begin
        launch_err <= 1'b1;
      end
      if (pop) begin
        proc_spawn_addr <= fifo_head;
        proc_onspawn    <= ~proc_onspawn;
        hold_cnt        <= HOLD_LOAD;
      end else if (emit_q == E_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      // Built from next-state terms so busy has no input-to-output path.
      proc_running <= (launch_nxt != IDLE) | ~fifo_empty_nxt
                    | (emit_nxt == E_HOLD);
    end
  end
endmodule

// File: tb/tb_proc_port.sv
// Directed plus randomized bench for proc_port against a
// cycle-indexed queue model of launch and spawn emission.
module tb_proc_port;
  import cluster_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 16;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  logic  proc_start = 1'b0;
  addr_t proc_start_addr = '0;
  logic  proc_running;
  addr_t proc_spawn_addr;
  logic  proc_onspawn;
  logic  launch_err;

  proc_port_if core ();

  proc_port #(
    .SPAWN_DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .proc_start     (proc_start),
    .proc_start_addr(proc_start_addr),
    .proc_running   (proc_running),
    .proc_spawn_addr(proc_spawn_addr),
    .proc_onspawn   (proc_onspawn),
    .launch_err     (launch_err),
    .core           (core.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index, launch busy flag, spawn queue,
  // and the earliest cycle the next emission may happen.
  int    cyc = 0;
  bit    m_prev, m_busy, m_go, m_err, m_tog;
  addr_t m_entry, m_saddr;
  addr_t m_q[$];
  int    next_ok = 0;
  bit    e_s, m_idle, m_act, m_rdy;

  always @(posedge clock) begin
    if (reset) begin
      m_prev = 0; m_busy = 0; m_go = 0; m_err = 0; m_tog = 0;
      m_entry = '0; m_saddr = '0; next_ok = 0;
      m_q.delete();
    end else begin
      e_s    = proc_start && !m_prev;
      m_prev = proc_start;
      m_idle = !m_busy;
      m_act  = m_busy && !m_go;
      if (!m_idle && e_s) m_err = 1;
      if (m_idle && e_s) begin
        m_entry = proc_start_addr;
        m_busy  = 1;
      end else if (m_act && core.core_done) begin
        m_busy = 0;
      end
      m_go  = m_idle && e_s;
      m_rdy = m_q.size() < DEPTH;
      if (m_q.size() > 0 && cyc >= next_ok) begin
        m_saddr = m_q.pop_front();
        m_tog   = ~m_tog;
        next_ok = cyc + HOLD + 1;
      end
      if (core.core_spawn_valid && m_rdy) m_q.push_back(core.core_spawn_addr);
    end
    cyc++;
  end

  int    go_cnt = 0;
  logic  last_tog = 1'b0;
  int    tog_t[$];
  addr_t tog_a[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit hold;
    hold = cyc < next_ok;
    chk("go", 32'(core.core_go), 32'(m_go));
    chk("entry", 32'(core.core_entry), 32'(m_entry));
    chk("err", 32'(launch_err), 32'(m_err));
    chk("running", 32'(proc_running),
        32'(m_busy || m_q.size() > 0 || hold));
    chk("saddr", 32'(proc_spawn_addr), 32'(m_saddr));
    chk("tog", 32'(proc_onspawn), 32'(m_tog));
    chk("ready", 32'(core.core_spawn_ready), 32'(m_q.size() < DEPTH));
    if (core.core_go === 1'b1) go_cnt++;
    if (proc_onspawn !== last_tog) begin
      tog_t.push_back(cyc);
      tog_a.push_back(proc_spawn_addr);
      last_tog = proc_onspawn;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && proc_running; i++) tick();
    chk("idle_timeout", 32'(proc_running), 32'd0);
  endtask

  int  g0, t0, fall;
  bit  saw_full;

  initial begin
    core.core_done = 0;
    core.core_spawn_valid = 0;
    core.core_spawn_addr = '0;
    repeat (3) tick();
    chk("rst_go", 32'(core.core_go), 32'd0);
    chk("rst_running", 32'(proc_running), 32'd0);
    chk("rst_tog", 32'(proc_onspawn), 32'd0);
    chk("rst_err", 32'(launch_err), 32'd0);
    chk("rst_entry", 32'(core.core_entry), 32'd0);
    chk("rst_saddr", 32'(proc_spawn_addr), 32'd0);
    chk("rst_ready", 32'(core.core_spawn_ready), 32'd1);
    reset = 0;
    tick();

    // Launch 0x3C, start held three cycles.
    g0 = go_cnt;
    proc_start = 1; proc_start_addr = 8'h3C;
    tick();
    chk("t1_go", 32'(core.core_go), 32'd1);
    chk("t1_running", 32'(proc_running), 32'd1);
    proc_start_addr = 8'hFF;
    tick();
    chk("t1_go_width", 32'(core.core_go), 32'd0);
    tick();
    proc_start = 0;
    tick();
    chk("t1_go_count", 32'(go_cnt - g0), 32'd1);
    chk("t1_entry", 32'(core.core_entry), 32'h3C);

    // Second edge while ACTIVE.
    proc_start = 1; proc_start_addr = 8'h55;
    tick();
    proc_start = 0;
    chk("t2_err", 32'(launch_err), 32'd1);
    tick(); tick();
    chk("t2_err_sticky", 32'(launch_err), 32'd1);
    chk("t2_no_go", 32'(go_cnt - g0), 32'd1);
    chk("t2_entry", 32'(core.core_entry), 32'h3C);
    core.core_done = 1;
    tick();
    core.core_done = 0;
    chk("t1_done_idle", 32'(proc_running), 32'd0);

    // Three back-to-back spawns.
    tog_t.delete(); tog_a.delete();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      core.core_spawn_valid = 1;
      core.core_spawn_addr = addr_t'(8'h10 + i);
      tick();
    end
    core.core_spawn_valid = 0;
    wait_idle();
    chk("t3_count", 32'(tog_t.size()), 32'd3);
    if (tog_t.size() >= 3) begin
      chk("t3_first", 32'(tog_t[0] - t0), 32'd2);
      chk("t3_gap1", 32'(tog_t[1] - tog_t[0]), 32'(HOLD + 1));
      chk("t3_gap2", 32'(tog_t[2] - tog_t[1]), 32'(HOLD + 1));
      for (int i = 0; i < 3; i++)
        chk("t3_addr", 32'(tog_a[i]), 32'h10 + 32'(i));
    end

    // Six spawns overflow a four-entry FIFO.
    tog_t.delete(); tog_a.delete();
    saw_full = 0;
    for (int i = 0; i < 6; i++) begin
      core.core_spawn_valid = 1;
      core.core_spawn_addr = addr_t'(8'h20 + i);
      for (int k = 0; k < 200 && !core.core_spawn_ready; k++) begin
        saw_full = 1;
        tick();
      end
      tick();
    end
    core.core_spawn_valid = 0;
    chk("t4_ready_dropped", 32'(saw_full), 32'd1);
    wait_idle();
    chk("t4_count", 32'(tog_a.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("t4_order", (i < tog_a.size()) ? 32'(tog_a[i]) : 32'hFFFF,
          32'h20 + 32'(i));

    // core_done while spawns are pending.
    tog_t.delete(); tog_a.delete();
    proc_start = 1; proc_start_addr = 8'h77;
    tick();
    proc_start = 0;
    core.core_spawn_valid = 1; core.core_spawn_addr = 8'h40;
    tick();
    core.core_spawn_addr = 8'h41;
    tick();
    core.core_spawn_valid = 0;
    core.core_done = 1;
    tick();
    core.core_done = 0;
    chk("t5_still_busy", 32'(proc_running), 32'd1);
    fall = -1;
    for (int i = 0; i < 400 && fall < 0; i++) begin
      tick();
      if (!proc_running) fall = cyc;
    end
    chk("t5_count", 32'(tog_t.size()), 32'd2);
    if (tog_t.size() == 2)
      chk("t5_fall_after_hold", 32'(fall - tog_t[1]), 32'(HOLD));

    // Reset during a hold with two entries queued.
    for (int i = 0; i < 3; i++) begin
      core.core_spawn_valid = 1;
      core.core_spawn_addr = addr_t'(8'h60 + i);
      tick();
    end
    core.core_spawn_valid = 0;
    tick(); tick();
    chk("t6_busy_before", 32'(proc_running), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_ready", 32'(core.core_spawn_ready), 32'd1);
    chk("t6_tog", 32'(proc_onspawn), 32'd0);
    chk("t6_running", 32'(proc_running), 32'd0);
    tog_t.delete(); tog_a.delete();
    repeat (60) tick();
    chk("t6_no_toggles", 32'(tog_t.size()), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      proc_start = ($urandom_range(0, 3) == 0);
      proc_start_addr = addr_t'($urandom);
      core.core_done = ($urandom_range(0, 7) == 0);
      core.core_spawn_valid = ($urandom_range(0, 5) == 0);
      core.core_spawn_addr = addr_t'($urandom);
      tick();
    end
    reset = 0; proc_start = 0;
    core.core_done = 0; core.core_spawn_valid = 0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
